// File: rtl/sequence_driver.sv
// Captures a full matrix on a valid pulse and streams it word-by-word over valid/ready.
// Optional SEQ_DRIVER_THROTTLE_EN inserts one idle cycle after every accepted non-last beat.
module sequence_driver #(
    parameter int MATRIX_SIZE = 64,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           sequence_i [MATRIX_SIZE],
    input  logic                  sequence_valid_i,
    output logic                  sequence_send_o,
    output logic [15:0]           data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  data_last_o,
    output logic                  mat_sel_o,
    output logic                  busy_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [15:0]             buf_q [MATRIX_SIZE];
    logic [15:0]             data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    send_q, send_d;
    logic                    mat_sel_q, mat_sel_d;
    logic                    busy_q, busy_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic                    load_en;
    logic                    accept;
`ifdef SEQ_DRIVER_THROTTLE_EN
    logic                    gap_q, gap_d;
`endif

    assign accept = valid_q & data_ready_i;

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        send_d    = 1'b0;
        mat_sel_d = mat_sel_q;
        drop_d    = drop_q;
        load_en   = 1'b0;
`ifdef SEQ_DRIVER_THROTTLE_EN
        gap_d     = gap_q;
`endif

        // A request outside IDLE is ignored but counted, saturating at all-ones.
        if (sequence_valid_i && state_q != IDLE && drop_q != {DROP_CNT_W{1'b1}})
            drop_d = drop_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (sequence_valid_i) begin
                    load_en = 1'b1;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = buf_q[0];
                valid_d = 1'b1;
                last_d  = (MATRIX_SIZE == 1);
                state_d = STREAM;
            end
            STREAM: begin
`ifdef SEQ_DRIVER_THROTTLE_EN
                if (gap_q) begin
                    valid_d = 1'b1;
                    last_d  = (idx_q == LAST_IDX);
                    gap_d   = 1'b0;
                end else
`endif
                if (accept) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        send_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = buf_q[idx_d];
`ifdef SEQ_DRIVER_THROTTLE_EN
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        gap_d   = 1'b1;
`else
                        last_d = (idx_d == LAST_IDX);
`endif
                    end
                end
            end
            DONE: begin
                mat_sel_d = ~mat_sel_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: the matrix buffer is cleared on reset too, so an aborted transfer leaves no stale words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            send_q    <= 1'b0;
            mat_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= '0;
            for (int i = 0; i < MATRIX_SIZE; i++) buf_q[i] <= '0;
`ifdef SEQ_DRIVER_THROTTLE_EN
            gap_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            send_q    <= send_d;
            mat_sel_q <= mat_sel_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            if (load_en) buf_q <= sequence_i;
`ifdef SEQ_DRIVER_THROTTLE_EN
            gap_q     <= gap_d;
`endif
        end
    end

    assign sequence_send_o = send_q;
    assign data_o          = data_q;
    assign data_valid_o    = valid_q;
    assign data_last_o     = last_q;
    assign mat_sel_o       = mat_sel_q;
    assign busy_o          = busy_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_sequence_driver.sv
// Directed bench for sequence_driver: streaming, stalls, A/B hand-off, drops, reset abort.
// Honours SEQ_DRIVER_THROTTLE_EN and `MATRIX_SIZE (defaults to 4).
`ifndef MATRIX_SIZE
`define MATRIX_SIZE 4
`endif
module tb_sequence_driver;

    localparam int MS = `MATRIX_SIZE;
`ifdef SEQ_DRIVER_THROTTLE_EN
    localparam int SEND_CYC = 2 * MS + 1;
`else
    localparam int SEND_CYC = MS + 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] seq [MS];
    logic        seq_valid;
    logic        ready;
    logic        send_o, valid_o, last_o, mat_sel_o, busy_o;
    logic [15:0] data_o;
    logic [7:0]  drop_o;

    logic        valid2, zero_ready;
    logic        s_send, s_valid, s_last, s_mat, s_busy;
    logic [15:0] s_data;
    logic [1:0]  s_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequence_driver #(.MATRIX_SIZE(MS), .DROP_CNT_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .sequence_i(seq), .sequence_valid_i(seq_valid),
        .sequence_send_o(send_o), .data_o(data_o), .data_valid_o(valid_o),
        .data_ready_i(ready), .data_last_o(last_o), .mat_sel_o(mat_sel_o),
        .busy_o(busy_o), .drop_cnt_o(drop_o)
    );

    sequence_driver #(.MATRIX_SIZE(MS), .DROP_CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .sequence_i(seq), .sequence_valid_i(valid2),
        .sequence_send_o(s_send), .data_o(s_data), .data_valid_o(s_valid),
        .data_ready_i(zero_ready), .data_last_o(s_last), .mat_sel_o(s_mat),
        .busy_o(s_busy), .drop_cnt_o(s_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] m [MS]);
        seq       = m;
        seq_valid = 1'b1;
        tick();
        seq_valid = 1'b0;
    endtask

    function automatic logic exp_valid(input int c);
`ifdef SEQ_DRIVER_THROTTLE_EN
        return (c >= 2) && (c <= 2 * MS) && (c % 2 == 0);
`else
        return (c >= 2) && (c <= MS + 1);
`endif
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (data_o    !== 16'd0) begin errors++; $display("FAIL reset_data got %0d want 0", data_o); end
        checks++; if (valid_o   !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (last_o    !== 1'b0)  begin errors++; $display("FAIL reset_last got %b want 0", last_o); end
        checks++; if (send_o    !== 1'b0)  begin errors++; $display("FAIL reset_send got %b want 0", send_o); end
        checks++; if (mat_sel_o !== 1'b0)  begin errors++; $display("FAIL reset_mat_sel got %b want 0", mat_sel_o); end
        checks++; if (busy_o    !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (drop_o    !== 8'd0)  begin errors++; $display("FAIL reset_drop got %0d want 0", drop_o); end
    endtask

    task automatic test_stream_basic();
        logic [15:0] m [MS];
        int k = 0, send_at = 0, sends = 0;
        logic mat0;
        for (int i = 0; i < MS; i++) m[i] = 16'(10 * (i + 1));
        mat0  = mat_sel_o;
        ready = 1'b1;
        pulse(m);
        for (int c = 1; c <= SEND_CYC + 2; c++) begin
            checks++;
            if (valid_o !== exp_valid(c)) begin
                errors++; $display("FAIL basic_valid cyc %0d got %b want %b", c, valid_o, exp_valid(c));
            end
            if (valid_o && ready && k < MS) begin
                checks++; if (data_o !== m[k]) begin errors++; $display("FAIL basic_data beat %0d got %0d want %0d", k, data_o, m[k]); end
                checks++; if (last_o !== (k == MS - 1)) begin errors++; $display("FAIL basic_last beat %0d got %b", k, last_o); end
                k++;
            end
            if (send_o) begin sends++; if (send_at == 0) send_at = c; end
            tick();
        end
        checks++; if (k != MS) begin errors++; $display("FAIL basic_beats got %0d want %0d", k, MS); end
        checks++; if (send_at != SEND_CYC) begin errors++; $display("FAIL basic_send_cycle got %0d want %0d", send_at, SEND_CYC); end
        checks++; if (sends != 1) begin errors++; $display("FAIL basic_send_width got %0d want 1", sends); end
        checks++; if (mat_sel_o !== ~mat0) begin errors++; $display("FAIL basic_mat_sel got %b want %b", mat_sel_o, ~mat0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy_o); end
    endtask

    task automatic test_stall();
        logic [15:0] m [MS];
        int k = 0, send_at = 0, stalls = 0;
        for (int i = 0; i < MS; i++) m[i] = 16'(10 * (i + 1));
        ready = 1'b1;
        pulse(m);
        for (int c = 1; c <= SEND_CYC + 10; c++) begin
            if (valid_o && k == 1 && stalls < 3) begin
                ready = 1'b0;
                stalls++;
                checks++; if (data_o !== m[1]) begin errors++; $display("FAIL stall_hold cyc %0d got %0d want %0d", c, data_o, m[1]); end
            end else begin
                ready = 1'b1;
            end
            if (valid_o && ready && k < MS) begin
                checks++; if (data_o !== m[k]) begin errors++; $display("FAIL stall_data beat %0d got %0d want %0d", k, data_o, m[k]); end
                k++;
            end
            if (send_o && send_at == 0) send_at = c;
            tick();
        end
        ready = 1'b1;
        checks++; if (stalls != 3) begin errors++; $display("FAIL stall_cycles got %0d want 3", stalls); end
        checks++; if (k != MS) begin errors++; $display("FAIL stall_beats got %0d want %0d", k, MS); end
        checks++; if (send_at != SEND_CYC + 3) begin errors++; $display("FAIL stall_send_cycle got %0d want %0d", send_at, SEND_CYC + 3); end
    endtask

    task automatic test_ab_run();
        logic [15:0] a [MS];
        logic [15:0] b [MS];
        logic [15:0] cur [MS];
        int sends = 0;
        for (int i = 0; i < MS; i++) begin
            a[i] = 16'($urandom_range(0, 50));
            b[i] = 16'($urandom_range(100, 150));
        end
        do_reset();
        ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            int k = 0;
            cur = (p == 0) ? a : b;
            pulse(cur);
            for (int c = 1; c <= SEND_CYC + 1; c++) begin
                if (valid_o && k < MS) begin
                    checks++; if (data_o !== cur[k]) begin errors++; $display("FAIL ab_data mat %0d beat %0d got %0d want %0d", p, k, data_o, cur[k]); end
                    k++;
                end
                if (send_o) sends++;
                tick();
            end
            checks++; if (mat_sel_o !== (p == 0)) begin errors++; $display("FAIL ab_mat_sel after %0d got %b want %b", p, mat_sel_o, (p == 0)); end
        end
        checks++; if (sends != 2) begin errors++; $display("FAIL ab_sends got %0d want 2", sends); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ab_idle got %b want 0", busy_o); end
    endtask

    task automatic test_drop();
        logic [15:0] m [MS];
        logic [15:0] junk [MS];
        int k = 0, sends = 0;
        for (int i = 0; i < MS; i++) begin
            m[i]    = 16'(200 + i);
            junk[i] = 16'(900 + i);
        end
        do_reset();
        ready = 1'b1;
        pulse(m);
        for (int c = 1; c <= SEND_CYC + 1; c++) begin
            if (valid_o && k < MS) begin
                checks++; if (data_o !== m[k]) begin errors++; $display("FAIL drop_data beat %0d got %0d want %0d", k, data_o, m[k]); end
                k++;
            end
            seq_valid = 1'b0;
            if (c == 3 || c == 4) begin
                seq       = junk;
                seq_valid = 1'b1;
            end
            if (send_o) begin
                sends++;
                checks++; if (drop_o !== 8'd2) begin errors++; $display("FAIL drop_mid got %0d want 2", drop_o); end
                seq_valid = 1'b1;
            end
            tick();
        end
        seq_valid = 1'b0;
        tick();
        checks++; if (sends != 1) begin errors++; $display("FAIL drop_sends got %0d want 1", sends); end
        checks++; if (drop_o !== 8'd3) begin errors++; $display("FAIL drop_done got %0d want 3", drop_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL drop_no_restart got %b want 0", busy_o); end
    endtask

    task automatic test_drop_saturate();
        logic [15:0] m [MS];
        for (int i = 0; i < MS; i++) m[i] = 16'(i);
        seq = m;
        do_reset();
        valid2 = 1'b1; tick(); valid2 = 1'b0;
        tick(); tick();
        checks++; if (s_drop !== 2'd0) begin errors++; $display("FAIL sat_start got %0d want 0", s_drop); end
        for (int n = 1; n <= 5; n++) begin
            valid2 = 1'b1; tick(); valid2 = 1'b0;
            checks++;
            if (s_drop !== 2'((n > 3) ? 3 : n)) begin
                errors++; $display("FAIL sat_count pulse %0d got %0d want %0d", n, s_drop, (n > 3) ? 3 : n);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] m [MS];
        logic [15:0] m2 [MS];
        int k = 0, sends = 0, guard = 0;
        for (int i = 0; i < MS; i++) begin
            m[i]  = 16'(300 + i);
            m2[i] = 16'(500 + i);
        end
        do_reset();
        ready = 1'b1;
        pulse(m);
        while (k < 2 && guard < SEND_CYC) begin
            if (valid_o && ready) k++;
            tick();
            guard++;
        end
        do_reset();
        checks++; if ({data_o, valid_o, last_o, send_o, mat_sel_o, busy_o, drop_o} !== '0) begin
            errors++; $display("FAIL abort_outputs got data %0d v %b l %b s %b m %b b %b d %0d want all 0",
                               data_o, valid_o, last_o, send_o, mat_sel_o, busy_o, drop_o);
        end
        for (int c = 0; c < MS + 4; c++) begin
            if (send_o) sends++;
            tick();
        end
        checks++; if (sends != 0) begin errors++; $display("FAIL abort_send got %0d want 0", sends); end
        pulse(m2);
        tick();
        checks++; if (valid_o !== 1'b1 || data_o !== m2[0]) begin
            errors++; $display("FAIL abort_restart got v %b data %0d want v 1 data %0d", valid_o, data_o, m2[0]);
        end
        for (int c = 0; c < SEND_CYC + 2; c++) tick();
    endtask

    initial begin
        rst        = 1'b0;
        seq_valid  = 1'b0;
        valid2     = 1'b0;
        zero_ready = 1'b0;
        ready      = 1'b1;
        for (int i = 0; i < MS; i++) seq[i] = '0;
        tick();
        test_reset();
        test_stream_basic();
        test_stall();
        test_ab_run();
        test_drop();
        test_drop_saturate();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
